threshold_preview_select: RTL and testbench
===========================================

Name: threshold_preview_select

Overview:
Parametrised multi-box threshold preview for the HDMI pipeline. It draws NUM_BOXES side-by-side copies of the camera frame, each binarised at a different threshold, and highlights the selected box with a border. It tracks a left/right selection that changes only at frame boundaries, positions the arrow sprite, and latches a confirmed threshold for the downstream binarisation stage. It sits between the frame-buffer read path and the video mux.

Parameters:
NUM_BOXES, 4, number of preview boxes (2..8)
PIX_W, 12, width of frame-buffer pixel and threshold
THRESH_STEP, 800, threshold of box i = (i+1)*THRESH_STEP, saturated to 2^PIX_W-1
X0, 8, left x of box 0
Y0, 200, top y of all boxes
BOX_W, 240, box width in pixels
BOX_H, 320, box height in pixels
BOX_GAP, 16, horizontal gap between boxes
BORDER, 4, highlight border thickness inside the selected box
ARROW_W, 100, arrow sprite width, used for centring
ARROW_Y, 560, arrow sprite y

Ports:
clk_in  input  1  pixel clock
rst_n_in  input  1  asynchronous active-low reset
hcount_in  input  11  current pixel x
vcount_in  input  10  current pixel y
pixel_in  input  PIX_W  frame-buffer value aligned with hcount_in/vcount_in
left_in  input  1  debounced left button (level)
right_in  input  1  debounced right button (level)
confirm_in  input  1  debounced confirm button (level)
pixel_out  output  1  1 = white, 0 = black
border_out  output  1  1 when pixel_out is a highlight-border pixel
select_out  output  $clog2(NUM_BOXES)  active selected box
arrow_x_out  output  11  arrow sprite x
arrow_y_out  output  10  arrow sprite y (constant ARROW_Y)
threshold_out  output  PIX_W  last confirmed threshold
threshold_valid_out  output  1  one-cycle pulse when threshold_out updates

Behaviour:
- Reset (async assert, sync release): all outputs 0 except arrow_x_out = X0+(BOX_W-ARROW_W)/2 (78 at defaults), arrow_y_out = ARROW_Y, threshold_out = THRESH_STEP (box 0); pending selection = 0; button edge registers = 0.
- Buttons: rising-edge detect on registered copy; a held button counts once.
- Pending selection: right edge -> +1, wrapping NUM_BOXES-1 -> 0; left edge -> -1, wrapping 0 -> NUM_BOXES-1; left and right edges in the same cycle -> no change.
- Active selection (select_out) loads pending only in the cycle hcount_in==0 && vcount_in==0; no mid-frame change, no tearing.
- arrow_x_out = X0 + sel*(BOX_W+BOX_GAP) + (BOX_W-ARROW_W)/2, registered, updated in the same cycle as select_out.
- Confirm: confirm_in rising edge -> next cycle threshold_out = threshold(select_out) (active, not pending) and threshold_valid_out = 1 for exactly one cycle. Coincident confirm and frame-start: uses the select_out value before the update.
- Box i region: X0+i*(BOX_W+BOX_GAP) <= x < that+BOX_W, Y0 <= y < Y0+BOX_H.
- Pixel pipeline, latency 2 cycles from hcount_in/vcount_in/pixel_in to pixel_out/border_out:
  stage 1: register box index, in-box flag, in-border flag (box==select_out and within BORDER of any box edge), pixel_in >= threshold(box).
  stage 2: border -> pixel_out=1, border_out=1; in box -> pixel_out=compare, border_out=0; else both 0.
- Threshold arithmetic at PIX_W+4 bits, saturated to PIX_W; constants precomputed, no runtime multiply.
- Reset mid-frame clears the pipeline; outputs 0 until refilled (2 cycles).

Test Plan:
- Reset then idle: select_out=0, arrow_x_out=78, arrow_y_out=560, threshold_out=800, pixel_out=0 outside boxes.
- Box 0 at (100,300): pixel_in=799 -> pixel_out=0, pixel_in=800 -> 1, each 2 cycles later; box 3 at (900,300): 3199 -> 0, 3200 -> 1.
- Four right pulses with frame start between each: select_out 1,2,3,0; arrow_x_out 334,590,846,78. Left from 0 -> 3. Right held 50 cycles -> single step.
- Right pulse mid-frame: select_out unchanged until (0,0), then 1; simultaneous left+right edge -> no change.
- select_out=2, confirm pulse -> threshold_out=2400, threshold_valid_out high exactly 1 cycle; held confirm -> no second pulse.
- select_out=1: (264,300) -> border_out=1, pixel_out=1; (268,300) -> border_out=0; rst_n_in low mid-line -> immediate reset values, 2-cycle refill.

Source files
------------

// File: rtl/threshold_preview_select.sv
// Side-by-side threshold preview boxes with frame-synchronous selection, arrow placement and confirm latch.
// Pixel path latency 2 cycles; no backpressure, runs free on the video timing.
module threshold_preview_select #(
    parameter int NUM_BOXES   = 4,
    parameter int PIX_W       = 12,
    parameter int THRESH_STEP = 800,
    parameter int X0          = 8,
    parameter int Y0          = 200,
    parameter int BOX_W       = 240,
    parameter int BOX_H       = 320,
    parameter int BOX_GAP     = 16,
    parameter int BORDER      = 4,
    parameter int ARROW_W     = 100,
    parameter int ARROW_Y     = 560,
    localparam int SEL_W      = $clog2(NUM_BOXES)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [10:0]      hcount_in,
    input  logic [9:0]       vcount_in,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             left_in,
    input  logic             right_in,
    input  logic             confirm_in,
    output logic             pixel_out,
    output logic             border_out,
    output logic [SEL_W-1:0] select_out,
    output logic [10:0]      arrow_x_out,
    output logic [9:0]       arrow_y_out,
    output logic [PIX_W-1:0] threshold_out,
    output logic             threshold_valid_out
);

    localparam int PITCH     = BOX_W + BOX_GAP;
    localparam int ARROW_OFF = (BOX_W - ARROW_W) / 2;

    localparam logic [9:0]  Y_TOP    = 10'(Y0);
    localparam logic [9:0]  Y_BOT    = 10'(Y0 + BOX_H);
    localparam logic [9:0]  Y_TOP_IN = 10'(Y0 + BORDER);
    localparam logic [9:0]  Y_BOT_IN = 10'(Y0 + BOX_H - BORDER);
    localparam logic [10:0] ARROW_X_RST = 11'(X0 + ARROW_OFF);

    // Widened product so large box counts saturate instead of wrapping at PIX_W.
    function automatic logic [PIX_W-1:0] sat_thresh(input int idx);
        logic [PIX_W+3:0] raw;
        raw = (PIX_W+4)'((idx + 1) * THRESH_STEP);
        if (raw > (PIX_W+4)'({PIX_W{1'b1}}))
            return {PIX_W{1'b1}};
        return raw[PIX_W-1:0];
    endfunction

    localparam logic [PIX_W-1:0] THRESH_RST = sat_thresh(0);

    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_pend;
    logic [10:0]      r_arrow_x;
    logic [PIX_W-1:0] r_thresh;
    logic             r_thresh_vld;
    logic             r_left_q;
    logic             r_right_q;
    logic             r_confirm_q;
    logic             r_s1_in_box;
    logic             r_s1_border;
    logic             r_s1_cmp;
    logic             r_pix;
    logic             r_border;

    logic [PIX_W-1:0]     w_thr     [NUM_BOXES];
    logic [10:0]          w_arrow_x [NUM_BOXES];
    logic [NUM_BOXES-1:0] w_in_box;
    logic [NUM_BOXES-1:0] w_near_edge;
    logic [NUM_BOXES-1:0] w_cmp;
    logic [NUM_BOXES-1:0] w_sel_hot;
    logic                 w_in_y;
    logic                 w_y_edge;
    logic                 w_left_edge;
    logic                 w_right_edge;
    logic                 w_confirm_edge;
    logic                 w_frame_start;
    logic [SEL_W-1:0]     w_pend_next;

    assign w_in_y   = (vcount_in >= Y_TOP) && (vcount_in < Y_BOT);
    assign w_y_edge = (vcount_in < Y_TOP_IN) || (vcount_in >= Y_BOT_IN);

    generate
        for (genvar gi = 0; gi < NUM_BOXES; gi++) begin : g_box
            localparam logic [10:0]      XL    = 11'(X0 + gi * PITCH);
            localparam logic [10:0]      XR    = 11'(X0 + gi * PITCH + BOX_W);
            localparam logic [10:0]      XL_IN = 11'(X0 + gi * PITCH + BORDER);
            localparam logic [10:0]      XR_IN = 11'(X0 + gi * PITCH + BOX_W - BORDER);
            localparam logic [PIX_W-1:0] THR   = sat_thresh(gi);

            assign w_thr[gi]       = THR;
            assign w_arrow_x[gi]   = 11'(X0 + gi * PITCH + ARROW_OFF);
            assign w_in_box[gi]    = w_in_y && (hcount_in >= XL) && (hcount_in < XR);
            assign w_near_edge[gi] = w_y_edge || (hcount_in < XL_IN) || (hcount_in >= XR_IN);
            assign w_cmp[gi]       = (pixel_in >= THR);
            assign w_sel_hot[gi]   = (r_sel == SEL_W'(gi));
        end
    endgenerate

    assign w_left_edge    = left_in & ~r_left_q;
    assign w_right_edge   = right_in & ~r_right_q;
    assign w_confirm_edge = confirm_in & ~r_confirm_q;
    assign w_frame_start  = (hcount_in == 11'd0) && (vcount_in == 10'd0);

    // Opposing edges in the same cycle cancel.
    always_comb begin
        w_pend_next = r_pend;
        if (w_right_edge && !w_left_edge) begin
            if (r_pend == SEL_W'(NUM_BOXES - 1))
                w_pend_next = '0;
            else
                w_pend_next = r_pend + 1'b1;
        end else if (w_left_edge && !w_right_edge) begin
            if (r_pend == '0)
                w_pend_next = SEL_W'(NUM_BOXES - 1);
            else
                w_pend_next = r_pend - 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sel        <= '0;
            r_pend       <= '0;
            r_arrow_x    <= ARROW_X_RST;
            r_thresh     <= THRESH_RST;
            r_thresh_vld <= 1'b0;
            r_left_q     <= 1'b0;
            r_right_q    <= 1'b0;
            r_confirm_q  <= 1'b0;
        end else begin
            r_left_q     <= left_in;
            r_right_q    <= right_in;
            r_confirm_q  <= confirm_in;
            r_pend       <= w_pend_next;
            r_thresh_vld <= w_confirm_edge;
            // Confirm reads the active box, so a coincident frame start sees the old selection.
            if (w_confirm_edge)
                r_thresh <= w_thr[r_sel];
            if (w_frame_start) begin
                r_sel     <= r_pend;
                r_arrow_x <= w_arrow_x[r_pend];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s1_in_box <= 1'b0;
            r_s1_border <= 1'b0;
            r_s1_cmp    <= 1'b0;
            r_pix       <= 1'b0;
            r_border    <= 1'b0;
        end else begin
            r_s1_in_box <= |w_in_box;
            r_s1_border <= |(w_in_box & w_near_edge & w_sel_hot);
            r_s1_cmp    <= |(w_in_box & w_cmp);
            r_pix       <= r_s1_border | (r_s1_in_box & r_s1_cmp);
            r_border    <= r_s1_border;
        end
    end

    assign pixel_out           = r_pix;
    assign border_out          = r_border;
    assign select_out          = r_sel;
    assign arrow_x_out         = r_arrow_x;
    assign arrow_y_out         = 10'(ARROW_Y);
    assign threshold_out       = r_thresh;
    assign threshold_valid_out = r_thresh_vld;

endmodule

// File: tb/tb_threshold_preview_select.sv
// Directed bench for threshold_preview_select; pixel results go through a 2-deep scoreboard queue.
`timescale 1ns/1ps
module tb_threshold_preview_select;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [11:0] pixel_in;
    logic        left_in, right_in, confirm_in;
    logic        pixel_out, border_out;
    logic [1:0]  select_out;
    logic [10:0] arrow_x_out;
    logic [9:0]  arrow_y_out;
    logic [11:0] threshold_out;
    logic        threshold_valid_out;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];
    logic drive_vld = 1'b0;
    logic vld_d1, vld_d2;

    threshold_preview_select dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .pixel_in(pixel_in),
        .left_in(left_in), .right_in(right_in), .confirm_in(confirm_in),
        .pixel_out(pixel_out), .border_out(border_out), .select_out(select_out),
        .arrow_x_out(arrow_x_out), .arrow_y_out(arrow_y_out),
        .threshold_out(threshold_out), .threshold_valid_out(threshold_valid_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_d1 <= 1'b0;
            vld_d2 <= 1'b0;
        end else begin
            vld_d1 <= drive_vld;
            vld_d2 <= vld_d1;
        end
    end

    always @(negedge clk_in) begin
        logic [1:0] e;
        if (vld_d2) begin
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL sb_underflow observed=0 expected=1");
            end else begin
                e = exp_q.pop_front();
                chk("sb_pixel_out", 32'(pixel_out), 32'(e[1]));
                chk("sb_border_out", 32'(border_out), 32'(e[0]));
            end
        end
    end

    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic go_idle();
        hcount_in = 11'd1100;
        vcount_in = 10'd600;
        pixel_in  = 12'd0;
    endtask

    task automatic pix(input int x, input int y, input int p, input logic ep, input logic eb);
        hcount_in = 11'(x);
        vcount_in = 10'(y);
        pixel_in  = 12'(p);
        exp_q.push_back({ep, eb});
        drive_vld = 1'b1;
        step();
        drive_vld = 1'b0;
    endtask

    task automatic drain();
        go_idle();
        repeat (3) step();
    endtask

    task automatic frame();
        hcount_in = 11'd0;
        vcount_in = 10'd0;
        step();
        go_idle();
    endtask

    task automatic press_right();
        right_in = 1'b1;
        step();
        right_in = 1'b0;
        step();
    endtask

    task automatic press_left();
        left_in = 1'b1;
        step();
        left_in = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL timeout observed=running expected=finished");
    end

    initial begin
        int exp_sel [4] = '{1, 2, 3, 0};
        int exp_ax  [4] = '{334, 590, 846, 78};
        left_in = 1'b0; right_in = 1'b0; confirm_in = 1'b0;
        go_idle();
        repeat (3) step();
        rst_n_in = 1'b1;
        step();
        step();

        chk("rst_select", 32'(select_out), 32'd0);
        chk("rst_arrow_x", 32'(arrow_x_out), 32'd78);
        chk("rst_arrow_y", 32'(arrow_y_out), 32'd560);
        chk("rst_threshold", 32'(threshold_out), 32'd800);
        chk("rst_thr_valid", 32'(threshold_valid_out), 32'd0);
        chk("rst_pixel", 32'(pixel_out), 32'd0);

        pix(1100, 600, 4095, 1'b0, 1'b0);
        pix(100, 300, 799, 1'b0, 1'b0);
        pix(100, 300, 800, 1'b1, 1'b0);
        pix(900, 300, 3199, 1'b0, 1'b0);
        pix(900, 300, 3200, 1'b1, 1'b0);
        pix(248, 300, 4095, 1'b0, 1'b0);
        drain();

        for (int i = 0; i < 4; i++) begin
            press_right();
            frame();
            chk("walk_select", 32'(select_out), 32'(exp_sel[i]));
            chk("walk_arrow_x", 32'(arrow_x_out), 32'(exp_ax[i]));
        end

        press_left();
        frame();
        chk("left_wrap", 32'(select_out), 32'd3);
        press_right();
        frame();
        chk("right_wrap", 32'(select_out), 32'd0);

        right_in = 1'b1;
        repeat (50) step();
        right_in = 1'b0;
        step();
        frame();
        chk("held_right", 32'(select_out), 32'd1);

        press_right();
        repeat (5) step();
        chk("midframe_hold", 32'(select_out), 32'd1);
        frame();
        chk("midframe_load", 32'(select_out), 32'd2);

        left_in = 1'b1; right_in = 1'b1;
        step();
        left_in = 1'b0; right_in = 1'b0;
        step();
        frame();
        chk("both_edges", 32'(select_out), 32'd2);

        confirm_in = 1'b1;
        step();
        chk("confirm_thr", 32'(threshold_out), 32'd2400);
        chk("confirm_pulse", 32'(threshold_valid_out), 32'd1);
        step();
        chk("confirm_one_cycle", 32'(threshold_valid_out), 32'd0);
        repeat (5) step();
        chk("confirm_held", 32'(threshold_valid_out), 32'd0);
        chk("confirm_thr_kept", 32'(threshold_out), 32'd2400);
        confirm_in = 1'b0;
        step();

        press_left();
        frame();
        chk("sel_box1", 32'(select_out), 32'd1);
        pix(264, 300, 0, 1'b1, 1'b1);
        pix(268, 300, 4095, 1'b1, 1'b0);
        pix(268, 300, 0, 1'b0, 1'b0);
        pix(300, 200, 0, 1'b1, 1'b1);
        pix(300, 519, 0, 1'b1, 1'b1);
        pix(520, 300, 0, 1'b0, 1'b0);
        pix(264, 520, 4095, 1'b0, 1'b0);
        drain();

        press_right();
        confirm_in = 1'b1;
        hcount_in = 11'd0;
        vcount_in = 10'd0;
        step();
        go_idle();
        chk("coincident_thr", 32'(threshold_out), 32'd1600);
        chk("coincident_pulse", 32'(threshold_valid_out), 32'd1);
        chk("coincident_sel", 32'(select_out), 32'd2);
        confirm_in = 1'b0;
        step();

        hcount_in = 11'd268;
        vcount_in = 10'd300;
        pixel_in  = 12'd4095;
        step();
        step();
        chk("prereset_pixel", 32'(pixel_out), 32'd1);
        #2 rst_n_in = 1'b0;
        #1;
        chk("arst_pixel", 32'(pixel_out), 32'd0);
        chk("arst_select", 32'(select_out), 32'd0);
        chk("arst_arrow_x", 32'(arrow_x_out), 32'd78);
        chk("arst_threshold", 32'(threshold_out), 32'd800);
        step();
        rst_n_in = 1'b1;
        step();
        chk("refill_1", 32'(pixel_out), 32'd0);
        step();
        chk("refill_2", 32'(pixel_out), 32'd1);

        drain();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
